md_issue_ctrl: RTL and testbench

- Issue/sequencing stage directly upstream of the negedge-clocked multiply/divide unit.
- Accepts one HI/LO-class instruction from the ID/EX boundary and holds the op code and operands stable to the unit until it completes.
- Captures the 32-bit result and hands it to writeback as a one-cycle pulse.
- Inserts flag-clearing bubbles between long ops, raises the pipeline stall, and runs a stall watchdog.

---
 rtl/md_pkg.sv | 38 +++
 rtl/md_issue_ctrl_watchdog.sv | 43 ++++
 rtl/md_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM state encoding and op-class predicates for the
// multiply/divide issue stage.
// Contents: MD_* op constants, md_state_e, is_legal_op / is_long_op / writes_gpr.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_DIV   = 4'd1;
  localparam logic [3:0] MD_DIVU  = 4'd2;
  localparam logic [3:0] MD_MFHI  = 4'd3;
  localparam logic [3:0] MD_MFLO  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MUL   = 4'd7;
  localparam logic [3:0] MD_MULT  = 4'd8;
  localparam logic [3:0] MD_MULTU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } md_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= MD_DIV) && (op <= MD_MULTU);
  endfunction

  // Ops that leave a sticky done flag in the unit and therefore need a
  // flag-clearing bubble afterwards.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MUL) || (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic writes_gpr(input logic [3:0] op);
    return (op == MD_MUL) || (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_watchdog.sv
// md_watchdog: saturating cycle counter with synchronous clear and enable,
// plus a sticky flag that rises once the count reaches MAX_CYC.
// Ports: clk, rst (sync, active-high), clr, en in; flag out.
module md_watchdog #(
  parameter int unsigned MAX_CYC = 40,
  parameter int unsigned CNT_W   = $clog2(MAX_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic flag
);

  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_W)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Clear only restarts the count; the flag is sticky until reset.
    flag_d = flag_q | (cnt_d == MAX_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/sequencing stage in front of the negedge-clocked
// multiply/divide unit. Holds op/operands stable until Md_stall drops,
// captures the result as a one-cycle writeback pulse, inserts an MFHI bubble
// after long ops, and runs a stall watchdog.
// Ports: Clk, Rst (sync, active-high); In_* request with In_ready/Pipe_stall;
// Flush; Md_op/Rs_out/Rt_out to the unit, Md_stall/Res_in from it;
// Wb_valid/Wb_rd/Wb_data writeback; Busy, Err status.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYC = 40
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        In_valid,
  input  logic [3:0]  In_md_op,
  input  logic [31:0] In_rs,
  input  logic [31:0] In_rt,
  input  logic [4:0]  In_rd,
  output logic        In_ready,
  input  logic        Flush,
  output logic [3:0]  Md_op,
  output logic [31:0] Rs_out,
  output logic [31:0] Rt_out,
  input  logic        Md_stall,
  input  logic [31:0] Res_in,
  output logic        Wb_valid,
  output logic [4:0]  Wb_rd,
  output logic [31:0] Wb_data,
  output logic        Pipe_stall,
  output logic        Busy,
  output logic        Err
);

  md_state_e   state_q, state_d;

  logic [3:0]  md_op_q, md_op_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic        kill_q, kill_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        ill_err_q, ill_err_d;

  logic        accept;
  logic        complete;
  logic        wd_en;
  logic        wd_flag;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ISSUE;
      ST_ISSUE:  if (complete) state_d = is_long_op(md_op_q) ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs / handshake decode
  // ---------------------------------------------------------------------
  always_comb begin
    In_ready   = (state_q == ST_IDLE);
    Busy       = (state_q != ST_IDLE);
    Pipe_stall = In_valid && (state_q != ST_IDLE);
    // Illegal ops are consumed in IDLE too, but never start an issue.
    accept     = (state_q == ST_IDLE) && In_valid && is_legal_op(In_md_op);
    complete   = (state_q == ST_ISSUE) && !Md_stall;
    wd_en      = (state_q == ST_ISSUE);
  end

  // ---------------------------------------------------------------------
  // Operand / result register bank
  // ---------------------------------------------------------------------
  always_comb begin
    md_op_d    = md_op_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    kill_d     = kill_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    ill_err_d  = ill_err_q;

    unique case (state_q)
      ST_IDLE: begin
        md_op_d = MD_NOP;
        if (accept) begin
          md_op_d = In_md_op;
          rs_d    = In_rs;
          rt_d    = In_rt;
          rd_d    = In_rd;
          kill_d  = 1'b0;
        end else if (In_valid) begin
          ill_err_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        // The unit cannot abort, so a flush only suppresses the writeback.
        if (Flush) kill_d = 1'b1;
        if (complete) begin
          if (writes_gpr(md_op_q) && !kill_q && !Flush) begin
            wb_valid_d = 1'b1;
            wb_data_d  = Res_in;
            wb_rd_d    = rd_q;
          end
          // Drop the op on the completion edge; a held DIV would restart.
          // Long ops get one MFHI cycle to clear the unit's sticky done flags.
          md_op_d = is_long_op(md_op_q) ? MD_MFHI : MD_NOP;
        end
      end
      ST_SETTLE: begin
        md_op_d = MD_NOP;
      end
      default: begin
        md_op_d = MD_NOP;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      md_op_q    <= MD_NOP;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      kill_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      ill_err_q  <= 1'b0;
    end else begin
      md_op_q    <= md_op_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      kill_q     <= kill_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      ill_err_q  <= ill_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stall watchdog: counts cycles spent in ISSUE, restarted on each accept.
  // ---------------------------------------------------------------------
  md_watchdog #(
    .MAX_CYC (WATCHDOG_CYC)
  ) u_watchdog (
    .clk  (Clk),
    .rst  (Rst),
    .clr  (accept),
    .en   (wd_en),
    .flag (wd_flag)
  );

  assign Md_op    = md_op_q;
  assign Rs_out   = rs_q;
  assign Rt_out   = rt_q;
  assign Wb_valid = wb_valid_q;
  assign Wb_rd    = wb_rd_q;
  assign Wb_data  = wb_data_q;
  assign Err      = ill_err_q | wd_flag;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed bench for md_issue_ctrl with a small negedge
// multiply/divide unit model (sticky done flags, 33-cycle divide).
// Scenarios: reset, MUL, DIV+MFLO/MFHI, MULTU back-to-back, MTHI, DIVU flush,
// flush kill, illegal op, watchdog.
module tb_md_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_valid;
  logic [3:0]  In_md_op;
  logic [31:0] In_rs, In_rt;
  logic [4:0]  In_rd;
  logic        In_ready;
  logic        Flush;
  logic [3:0]  Md_op;
  logic [31:0] Rs_out, Rt_out;
  logic        Md_stall;
  logic [31:0] Res_in;
  logic        Wb_valid;
  logic [4:0]  Wb_rd;
  logic [31:0] Wb_data;
  logic        Pipe_stall, Busy, Err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  md_issue_ctrl #(.WATCHDOG_CYC(40)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_md_op(In_md_op),
    .In_rs(In_rs), .In_rt(In_rt), .In_rd(In_rd), .In_ready(In_ready),
    .Flush(Flush), .Md_op(Md_op), .Rs_out(Rs_out), .Rt_out(Rt_out),
    .Md_stall(Md_stall), .Res_in(Res_in), .Wb_valid(Wb_valid), .Wb_rd(Wb_rd),
    .Wb_data(Wb_data), .Pipe_stall(Pipe_stall), .Busy(Busy), .Err(Err)
  );

  // ---------------- unit model ----------------
  logic [31:0] hi_r = '0, lo_r = '0;
  logic        mul_done = 1'b0, div_done = 1'b0, force_stall = 1'b0;
  logic [5:0]  div_cnt = '0;

  always @(negedge Clk) begin
    case (Md_op)
      4'd3: begin mul_done <= 1'b0; div_done <= 1'b0; div_cnt <= '0; end
      4'd5: hi_r <= Rs_out;
      4'd6: lo_r <= Rs_out;
      4'd7: if (!mul_done) begin lo_r <= Rs_out * Rt_out; mul_done <= 1'b1; end
      4'd8: if (!mul_done) begin
              {hi_r, lo_r} <= $signed({{32{Rs_out[31]}}, Rs_out}) * $signed({{32{Rt_out[31]}}, Rt_out});
              mul_done <= 1'b1;
            end
      4'd9: if (!mul_done) begin {hi_r, lo_r} <= {32'd0, Rs_out} * {32'd0, Rt_out}; mul_done <= 1'b1; end
      4'd1: if (!div_done) begin
              if (div_cnt == 6'd32) begin
                lo_r <= $signed(Rs_out) / $signed(Rt_out);
                hi_r <= $signed(Rs_out) % $signed(Rt_out);
                div_done <= 1'b1;
              end else div_cnt <= div_cnt + 6'd1;
            end
      4'd2: if (!div_done) begin
              if (div_cnt == 6'd32) begin
                lo_r <= Rs_out / Rt_out;
                hi_r <= Rs_out % Rt_out;
                div_done <= 1'b1;
              end else div_cnt <= div_cnt + 6'd1;
            end
      default: ;
    endcase
  end

  assign Md_stall = force_stall ||
                    ((Md_op == 4'd7 || Md_op == 4'd8 || Md_op == 4'd9) && !mul_done) ||
                    ((Md_op == 4'd1 || Md_op == 4'd2) && !div_done);
  assign Res_in = (Md_op == 4'd3) ? hi_r : lo_r;

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] rd);
    In_valid = 1'b1; In_md_op = op; In_rs = rs; In_rt = rt; In_rd = rd;
    step();
    In_valid = 1'b0; In_md_op = 4'd0;
  endtask

  // Issues a one-cycle op and returns what was observed; callers compare.
  task automatic run_short(input logic [3:0] op, input logic [31:0] rs, input logic [4:0] rd,
                           output logic busy_i, output logic [3:0] op_i, output logic wbv,
                           output logic [4:0] wrd, output logic [31:0] wdat, output logic busy_d);
    issue(op, rs, 32'd0, rd);
    busy_i = Busy; op_i = Md_op;
    step();
    wbv = Wb_valid; wrd = Wb_rd; wdat = Wb_data; busy_d = Busy;
  endtask

  // Walks a long op until idle, counting observations (bounded).
  task automatic walk_long(input logic [3:0] op, input int flush_at,
                           output int n_busy, output int n_op, output int n_set, output int n_wb);
    n_busy = 0; n_op = 0; n_set = 0; n_wb = 0;
    for (int i = 0; i < 60; i++) begin
      if (!Busy) break;
      n_busy++;
      if (Md_op == op) n_op++;
      if (Md_op == 4'd3) n_set++;
      if (Wb_valid) n_wb++;
      Flush = (i == flush_at);
      step();
    end
    Flush = 1'b0;
  endtask

  logic        bi, bd, wv;
  logic [3:0]  oi;
  logic [4:0]  wr;
  logic [31:0] wd;
  int          nb, no, ns, nw;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Rst = 1'b1; In_valid = 1'b1; In_md_op = 4'd7; In_rs = 32'd1; In_rt = 32'd1; In_rd = 5'd1; Flush = 1'b0;
    repeat (3) step();
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", Busy); end
    n_cmp++; if (Md_op !== 4'd0) begin n_err++; $display("FAIL reset_md_op: got %0d want 0", Md_op); end
    n_cmp++; if (Rs_out !== 32'd0 || Rt_out !== 32'd0) begin n_err++; $display("FAIL reset_operands: got %h %h want 0 0", Rs_out, Rt_out); end
    n_cmp++; if (Wb_valid !== 1'b0 || Wb_rd !== 5'd0 || Wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb: got %b %0d %h want 0 0 0", Wb_valid, Wb_rd, Wb_data); end
    n_cmp++; if (Err !== 1'b0 || In_ready !== 1'b1) begin n_err++; $display("FAIL reset_err_ready: got %b %b want 0 1", Err, In_ready); end
    In_valid = 1'b0; Rst = 1'b0;
    step();
  endtask

  task automatic test_mul();
    issue(4'd7, 32'd7, 32'hFFFF_FFFD, 5'd5);
    n_cmp++; if (Busy !== 1'b1 || Md_op !== 4'd7) begin n_err++; $display("FAIL mul_issue: got busy=%b op=%0d want 1 7", Busy, Md_op); end
    n_cmp++; if (Rs_out !== 32'd7 || Rt_out !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mul_operands: got %h %h want 7 fffffffd", Rs_out, Rt_out); end
    step();
    n_cmp++; if (Wb_valid !== 1'b1 || Wb_data !== 32'hFFFF_FFEB || Wb_rd !== 5'd5) begin n_err++; $display("FAIL mul_wb: got %b %h %0d want 1 ffffffeb 5", Wb_valid, Wb_data, Wb_rd); end
    n_cmp++; if (Md_op !== 4'd3) begin n_err++; $display("FAIL mul_settle_op: got %0d want 3", Md_op); end
    step();
    n_cmp++; if (Wb_valid !== 1'b0 || Md_op !== 4'd0 || In_ready !== 1'b1) begin n_err++; $display("FAIL mul_idle: got wb=%b op=%0d rdy=%b want 0 0 1", Wb_valid, Md_op, In_ready); end
  endtask

  task automatic test_div();
    issue(4'd1, 32'hFFFF_FFF9, 32'd2, 5'd0);
    In_valid = 1'b1; In_md_op = 4'd7; #1;
    n_cmp++; if (Pipe_stall !== 1'b1 || In_ready !== 1'b0) begin n_err++; $display("FAIL div_pipe_stall: got %b rdy=%b want 1 0", Pipe_stall, In_ready); end
    In_valid = 1'b0; In_md_op = 4'd0; #1;
    walk_long(4'd1, -1, nb, no, ns, nw);
    n_cmp++; if (nb !== 34 || no !== 33 || ns !== 1) begin n_err++; $display("FAIL div_timing: got busy=%0d div=%0d settle=%0d want 34 33 1", nb, no, ns); end
    n_cmp++; if (nw !== 0) begin n_err++; $display("FAIL div_no_wb: got %0d pulses want 0", nw); end
    run_short(4'd4, 32'd0, 5'd8, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'hFFFF_FFFD || wr !== 5'd8 || bd !== 1'b0) begin n_err++; $display("FAIL div_mflo: got %b %h %0d busy=%b want 1 fffffffd 8 0", wv, wd, wr, bd); end
    run_short(4'd3, 32'd0, 5'd9, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'hFFFF_FFFF || wr !== 5'd9) begin n_err++; $display("FAIL div_mfhi: got %b %h %0d want 1 ffffffff 9", wv, wd, wr); end
  endtask

  task automatic test_multu_b2b();
    issue(4'd9, 32'hFFFF_FFFF, 32'd2, 5'd0);
    step();
    n_cmp++; if (Wb_valid !== 1'b0 || Md_op !== 4'd3) begin n_err++; $display("FAIL multu_complete: got wb=%b op=%0d want 0 3", Wb_valid, Md_op); end
    step();
    run_short(4'd3, 32'd0, 5'd1, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'h0000_0001 || wr !== 5'd1) begin n_err++; $display("FAIL multu_mfhi: got %b %h %0d want 1 00000001 1", wv, wd, wr); end
    run_short(4'd4, 32'd0, 5'd2, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'hFFFF_FFFE || wr !== 5'd2) begin n_err++; $display("FAIL multu_mflo: got %b %h %0d want 1 fffffffe 2", wv, wd, wr); end
    issue(4'd9, 32'd5, 32'd5, 5'd0);
    step(); step();
    issue(4'd7, 32'd3, 32'd4, 5'd6);
    n_cmp++; if (Md_stall !== 1'b1) begin n_err++; $display("FAIL b2b_first_cycle_stall: got %b want 1", Md_stall); end
    step();
    n_cmp++; if (Wb_valid !== 1'b1 || Wb_data !== 32'd12 || Wb_rd !== 5'd6) begin n_err++; $display("FAIL b2b_mul_wb: got %b %h %0d want 1 0000000c 6", Wb_valid, Wb_data, Wb_rd); end
    step();
  endtask

  task automatic test_mthi();
    run_short(4'd5, 32'h1234_5678, 5'd3, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (bi !== 1'b1 || oi !== 4'd5 || wv !== 1'b0 || bd !== 1'b0) begin n_err++; $display("FAIL mthi: got busy=%b op=%0d wb=%b busy_after=%b want 1 5 0 0", bi, oi, wv, bd); end
    run_short(4'd3, 32'd0, 5'd3, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'h1234_5678 || wr !== 5'd3) begin n_err++; $display("FAIL mthi_mfhi: got %b %h %0d want 1 12345678 3", wv, wd, wr); end
  endtask

  task automatic test_divu_flush();
    issue(4'd2, 32'd100, 32'd7, 5'd4);
    walk_long(4'd2, 9, nb, no, ns, nw);
    n_cmp++; if (nb !== 34 || no !== 33 || ns !== 1 || nw !== 0) begin n_err++; $display("FAIL divu_flush: got busy=%0d divu=%0d settle=%0d wb=%0d want 34 33 1 0", nb, no, ns, nw); end
    run_short(4'd4, 32'd0, 5'd10, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'd14 || wr !== 5'd10) begin n_err++; $display("FAIL divu_mflo: got %b %h %0d want 1 0000000e 10", wv, wd, wr); end
    n_cmp++; if (Err !== 1'b0) begin n_err++; $display("FAIL no_err_so_far: got %b want 0", Err); end
  endtask

  task automatic test_flush();
    force_stall = 1'b1;
    issue(4'd7, 32'd5, 32'd6, 5'd11);
    step(); Flush = 1'b1; step(); Flush = 1'b0; step();
    n_cmp++; if (Md_op !== 4'd7 || Busy !== 1'b1) begin n_err++; $display("FAIL kill_hold: got op=%0d busy=%b want 7 1", Md_op, Busy); end
    force_stall = 1'b0;
    walk_long(4'd7, -1, nb, no, ns, nw);
    n_cmp++; if (nw !== 0 || ns !== 1) begin n_err++; $display("FAIL kill_no_wb: got wb=%0d settle=%0d want 0 1", nw, ns); end
    issue(4'd7, 32'd2, 32'd3, 5'd12);
    Flush = 1'b1; step(); Flush = 1'b0;
    n_cmp++; if (Wb_valid !== 1'b0 || Md_op !== 4'd3) begin n_err++; $display("FAIL flush_at_edge: got wb=%b op=%0d want 0 3", Wb_valid, Md_op); end
    step();
    run_short(4'd4, 32'd0, 5'd13, bi, oi, wv, wr, wd, bd);
    n_cmp++; if (wv !== 1'b1 || wd !== 32'd6 || wr !== 5'd13) begin n_err++; $display("FAIL flush_side_effect: got %b %h %0d want 1 00000006 13", wv, wd, wr); end
  endtask

  task automatic test_illegal();
    In_valid = 1'b1; In_md_op = 4'd12; #1;
    n_cmp++; if (In_ready !== 1'b1 || Pipe_stall !== 1'b0) begin n_err++; $display("FAIL illegal_ready: got %b stall=%b want 1 0", In_ready, Pipe_stall); end
    step();
    In_valid = 1'b0; In_md_op = 4'd0;
    n_cmp++; if (Err !== 1'b1 || Busy !== 1'b0 || Md_op !== 4'd0) begin n_err++; $display("FAIL illegal_err: got err=%b busy=%b op=%0d want 1 0 0", Err, Busy, Md_op); end
    Rst = 1'b1; step(); Rst = 1'b0;
    n_cmp++; if (Err !== 1'b0) begin n_err++; $display("FAIL illegal_rst_clear: got %b want 0", Err); end
  endtask

  task automatic test_watchdog();
    force_stall = 1'b1;
    issue(4'd7, 32'd1, 32'd1, 5'd14);
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 39) begin n_cmp++; if (Err !== 1'b0) begin n_err++; $display("FAIL wd_before: got %b want 0 at issue+39", Err); end end
      if (k == 40) begin n_cmp++; if (Err !== 1'b1) begin n_err++; $display("FAIL wd_at_40: got %b want 1", Err); end end
    end
    n_cmp++; if (Err !== 1'b1 || Busy !== 1'b1 || Md_op !== 4'd7) begin n_err++; $display("FAIL wd_sticky: got err=%b busy=%b op=%0d want 1 1 7", Err, Busy, Md_op); end
    Rst = 1'b1; step();
    n_cmp++; if (Err !== 1'b0 || Busy !== 1'b0 || Md_op !== 4'd0 || Rs_out !== 32'd0 || Rt_out !== 32'd0 ||
                 Wb_valid !== 1'b0 || Wb_rd !== 5'd0 || Wb_data !== 32'd0 || In_ready !== 1'b1) begin
      n_err++; $display("FAIL wd_reset: got err=%b busy=%b op=%0d rs=%h rt=%h wb=%b rd=%0d dat=%h rdy=%b want all reset", Err, Busy, Md_op, Rs_out, Rt_out, Wb_valid, Wb_rd, Wb_data, In_ready);
    end
    Rst = 1'b0; force_stall = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_multu_b2b();
    test_mthi();
    test_divu_flush();
    test_flush();
    test_illegal();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
